// File: rtl/camera_capture_writer.sv
// camera_capture_writer: decimating RGB565 camera capture into a framebuffer write port.
// Ports:
//   clk        camera pixel clock, all logic rising-edge
//   rst_n      asynchronous active-low reset
//   vsync      frame sync, high = vertical blanking
//   href       line valid, high = d carries pixel bytes
//   d          camera byte, two bytes per RGB565 pixel
//   wr_en      framebuffer write strobe, one cycle per stored pixel
//   wr_addr    framebuffer address, line*IMAGE_SIZE_H+column
//   wr_data    RGB565 pixel
//   frame_done one-cycle pulse when a captured frame closes
//   overflow   sticky, a decimated pixel fell outside the stored window
// Build option: define CAPTURE_BYTE_SWAP_EN to treat the first byte of each pixel as the low byte.
module camera_capture_writer #(
    parameter int IMAGE_SIZE_H = 160,
    parameter int IMAGE_SIZE_V = 120,
    parameter int DECIM        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_done,
    output logic        overflow
);
    typedef enum logic [1:0] {WAIT_SYNC, ARMED, CAPTURE} state_t;
    state_t      state, state_next;
    logic [15:0] src_pix, src_line, pixel, addr;
    logic [7:0]  first_byte;
    logic        phase, href_q, capturing, pix_done, store, in_window;
    logic [31:0] col, row;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= WAIT_SYNC;
        else        state <= state_next;

    always_comb
        state_next = (state == WAIT_SYNC && vsync)  ? ARMED   :
                     (state == ARMED     && !vsync) ? CAPTURE :
                     (state == CAPTURE   && vsync)  ? ARMED   : state;

    // vsync high in CAPTURE closes the frame and takes priority over any pixel activity
    always_comb begin
        frame_done = state == CAPTURE && vsync;
        capturing  = state == CAPTURE && !vsync;
    end

`ifdef CAPTURE_BYTE_SWAP_EN
    assign pixel = {d, first_byte};
`else
    assign pixel = {first_byte, d};
`endif

    assign col       = 32'(src_pix) / DECIM;
    assign row       = 32'(src_line) / DECIM;
    assign pix_done  = capturing && href && phase;
    assign store     = pix_done && 32'(src_pix) % DECIM == 0 && 32'(src_line) % DECIM == 0;
    assign in_window = col < IMAGE_SIZE_H && row < IMAGE_SIZE_V;
    assign addr      = 16'(row * IMAGE_SIZE_H + col);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            overflow   <= 1'b0;
            src_pix    <= '0;
            src_line   <= '0;
            phase      <= 1'b0;
            first_byte <= '0;
            href_q     <= 1'b0;
        end else begin
            // only href seen while capturing can produce a line-end edge
            href_q <= capturing && href;
            wr_en  <= store && in_window;
            if (store && in_window) begin
                wr_addr <= addr;
                wr_data <= pixel;
            end
            if (store && !in_window) overflow <= 1'b1;
            if (state == ARMED) begin
                src_pix    <= '0;
                src_line   <= '0;
                phase      <= 1'b0;
                first_byte <= '0;
            end else if (capturing) begin
                if (href) begin
                    phase <= ~phase;
                    if (!phase) first_byte <= d;
                    else if (src_pix != '1) src_pix <= src_pix + 16'd1;
                end else if (href_q) begin
                    // line end: an unpaired trailing byte is dropped with the phase
                    src_pix <= '0;
                    phase   <= 1'b0;
                    if (src_line != '1) src_line <= src_line + 16'd1;
                end
            end
        end
endmodule

// File: tb/tb_camera_capture_writer.sv
// tb_camera_capture_writer: randomized self-checking bench for camera_capture_writer.
module tb_camera_capture_writer;
    localparam int H = 160, V = 120, DEC = 4;
    logic        clk = 0, rst_n = 0, vsync = 0, href = 0;
    logic [7:0]  d = 0;
    logic        wr_en, frame_done, overflow;
    logic [15:0] wr_addr, wr_data;
    int          checks = 0, failures = 0, fd_cnt = 0;
    logic [31:0] exp_q[$], got_q[$];
    logic        exp_ovf = 0, fd_at_rise = 0;

    camera_capture_writer dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) got_q.push_back({wr_addr, wr_data});
        if (frame_done) fd_cnt++;
    end

    task automatic cyc(input logic v, input logic h, input logic [7:0] b);
        vsync = v; href = h; d = b;
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] pix_byte(input logic [15:0] v, input int k);
`ifdef CAPTURE_BYTE_SWAP_EN
        return k == 0 ? v[7:0] : v[15:8];
`else
        return k == 0 ? v[15:8] : v[7:0];
`endif
    endfunction

    // reference: decimate, place in window, or flag overflow
    task automatic expect_pixel(input int line, input int pix, input logic [15:0] v);
        if (line % DEC == 0 && pix % DEC == 0) begin
            if (pix / DEC < H && line / DEC < V) exp_q.push_back({16'(line / DEC * H + pix / DEC), v});
            else exp_ovf = 1;
        end
    endtask

    task automatic drive_line(input int line, input int nbytes, input bit idx_mode, input int gap);
        logic [15:0] v = 0;
        for (int b = 0; b < nbytes; b++) begin
            if (b % 2 == 0) v = idx_mode ? 16'(line * 640 + b / 2) : 16'($urandom);
            cyc(0, 1, pix_byte(v, b % 2));
            if (b % 2 == 1) expect_pixel(line, b / 2, v);
        end
        for (int g = 0; g < gap; g++) cyc(0, 0, 8'($urandom));
    endtask

    task automatic frame_start();
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);
    endtask

    task automatic frame_end();
        vsync = 1; href = 0;
        #2 fd_at_rise = frame_done;
        @(posedge clk); #1;
        cyc(1, 0, 0); cyc(1, 0, 0);
    endtask

    task automatic drive_frame(input int wpix, input int nlines, input bit idx_mode);
        frame_start();
        for (int l = 0; l < nlines; l++) drive_line(l, (l % DEC != 0) ? 2 : 2 * wpix, idx_mode, 1);
        frame_end();
    endtask

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 0; exp_ovf = 0;
        cyc(0, 0, 0); cyc(0, 0, 0);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== 16'h0) begin failures++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        checks++; if (wr_data !== 16'h0) begin failures++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst_n = 1;
        cyc(0, 0, 0);
    endtask

    task automatic test_pre_vsync();
        got_q.delete();
        for (int i = 0; i < 40; i++) cyc(0, 1'($urandom), 8'($urandom));
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL pre_vsync_writes: got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_byte_pair();
        logic [15:0] exp_v;
        int fd0 = fd_cnt;
`ifdef CAPTURE_BYTE_SWAP_EN
        exp_v = 16'hCDAB;
`else
        exp_v = 16'hABCD;
`endif
        got_q.delete();
        cyc(1, 0, 0); cyc(0, 0, 0);
        cyc(0, 1, 8'hAB);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL pair_first_byte_wr_en: got %b expected 0", wr_en); end
        cyc(0, 1, 8'hCD);
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL pair_wr_en: got %b expected 1", wr_en); end
        checks++; if (wr_data !== exp_v) begin failures++; $display("FAIL pair_wr_data: got %h expected %h", wr_data, exp_v); end
        checks++; if (wr_addr !== 16'h0) begin failures++; $display("FAIL pair_wr_addr: got %h expected 0", wr_addr); end
        cyc(0, 0, 8'h11);
        checks++; if (wr_en !== 1'b0 || wr_data !== exp_v) begin failures++; $display("FAIL pair_hold: got en=%b data=%h expected en=0 data=%h", wr_en, wr_data, exp_v); end
        frame_end();
        checks++; if (fd_at_rise !== 1'b1) begin failures++; $display("FAIL pair_frame_done: got %b expected 1", fd_at_rise); end
        checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL pair_frame_done_count: got %0d expected 1", fd_cnt - fd0); end
    endtask

    task automatic test_full_frame();
        int fd0 = fd_cnt, bad = -1;
        logic [15:0] v1;
        got_q.delete(); exp_q.delete();
        drive_frame(640, 480, 1);
        checks++; if (got_q.size() != 19200) begin failures++; $display("FAIL full_count: got %0d expected 19200", got_q.size()); end
        foreach (got_q[i]) if (bad < 0 && got_q[i][31:16] !== 16'(i)) bad = i;
        checks++; if (bad != -1) begin failures++; $display("FAIL full_addr_order: got addr %h at index %0d expected %h", got_q[bad][31:16], bad, 16'(bad)); end
        v1 = got_q.size() > 1 ? got_q[1][15:0] : 'x;
        checks++; if (v1 !== 16'd4) begin failures++; $display("FAIL full_addr1_value: got %h expected 0004", v1); end
        bad = first_diff();
        checks++; if (bad != -1) begin failures++; $display("FAIL full_model: got %h at index %0d expected %h", got_q[bad], bad, exp_q[bad]); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_overflow: got %b expected 0", overflow); end
        checks++; if (fd_at_rise !== 1'b1 || fd_cnt - fd0 != 1) begin failures++; $display("FAIL full_frame_done: got rise=%b count=%0d expected 1 and 1", fd_at_rise, fd_cnt - fd0); end
    endtask

    task automatic test_odd_line();
        int bad;
        got_q.delete(); exp_q.delete();
        frame_start();
        for (int l = 0; l < 9; l++) drive_line(l, (l == 3 || l == 7) ? 641 : 2 * $urandom_range(60, 20), 0, 1);
        frame_end();
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL odd_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        bad = first_diff();
        checks++; if (bad != -1) begin failures++; $display("FAIL odd_model: got %h at index %0d expected %h", got_q[bad], bad, exp_q[bad]); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            int fd0, bad, nlines;
            fd0 = fd_cnt;
            got_q.delete(); exp_q.delete();
            nlines = $urandom_range(12, 1);
            frame_start();
            for (int l = 0; l < nlines; l++) drive_line(l, $urandom_range(80, 1), 0, $urandom_range(3, 1));
            frame_end();
            checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count f%0d: got %0d expected %0d", f, got_q.size(), exp_q.size()); end
            bad = first_diff();
            checks++; if (bad != -1) begin failures++; $display("FAIL rand_model f%0d: got %h at index %0d expected %h", f, got_q[bad], bad, exp_q[bad]); end
            checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL rand_overflow f%0d: got %b expected %b", f, overflow, exp_ovf); end
            checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL rand_frame_done f%0d: got %0d expected 1", f, fd_cnt - fd0); end
        end
    endtask

    task automatic test_vsync_cut();
        int bad;
        got_q.delete(); exp_q.delete();
        frame_start();
        drive_line(0, 16, 0, 1);
        for (int l = 1; l < 4; l++) drive_line(l, 4, 0, 1);
        drive_line(4, 8, 0, 0);
        cyc(0, 1, 8'($urandom));
        frame_end();
        checks++; if (fd_at_rise !== 1'b1) begin failures++; $display("FAIL cut_mid_pixel_frame_done: got %b expected 1", fd_at_rise); end
        bad = first_diff();
        checks++; if (got_q.size() != exp_q.size() || bad != -1) begin failures++; $display("FAIL cut_mid_pixel_writes: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
        got_q.delete(); exp_q.delete();
        frame_start();
        drive_line(0, 8, 0, 0);
        cyc(0, 1, 8'($urandom));
        vsync = 1; href = 1; d = 8'($urandom);
        #2 fd_at_rise = frame_done;
        @(posedge clk); #1;
        cyc(1, 0, 0);
        checks++; if (fd_at_rise !== 1'b1) begin failures++; $display("FAIL cut_collide_frame_done: got %b expected 1", fd_at_rise); end
        bad = first_diff();
        checks++; if (got_q.size() != exp_q.size() || bad != -1) begin failures++; $display("FAIL cut_collide_writes: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
        got_q.delete(); exp_q.delete();
        frame_start();
        drive_line(0, 2, 0, 1);
        frame_end();
        bad = first_diff();
        checks++; if (got_q.size() != 1 || bad != -1) begin failures++; $display("FAIL cut_next_frame: got %0d writes expected 1 at addr 0", got_q.size()); end
    endtask

    task automatic test_overflow();
        int fd0 = fd_cnt, bad, max_a = 0;
        got_q.delete(); exp_q.delete();
        drive_frame(700, 500, 0);
        foreach (got_q[i]) if (int'(got_q[i][31:16]) > max_a) max_a = int'(got_q[i][31:16]);
        checks++; if (overflow !== 1'b1 || exp_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected %b", overflow, exp_ovf); end
        checks++; if (!(max_a < 19200)) begin failures++; $display("FAIL ovf_max_addr: got %0d expected below 19200", max_a); end
        checks++; if (got_q.size() != 19200) begin failures++; $display("FAIL ovf_count: got %0d expected 19200", got_q.size()); end
        bad = first_diff();
        checks++; if (bad != -1) begin failures++; $display("FAIL ovf_model: got %h at index %0d expected %h", got_q[bad], bad, exp_q[bad]); end
        checks++; if (fd_at_rise !== 1'b1 || fd_cnt - fd0 != 1) begin failures++; $display("FAIL ovf_frame_done: got rise=%b count=%0d expected 1 and 1", fd_at_rise, fd_cnt - fd0); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        rst_n = 0; cyc(0, 0, 0); rst_n = 1; cyc(0, 0, 0);
        exp_ovf = 0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_clears_overflow: got %b expected 0", overflow); end
        got_q.delete(); exp_q.delete();
        frame_start();
        drive_line(0, 40, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'($urandom));
        #2 rst_n = 0;
        #1;
        checks++; if (wr_en !== 1'b0 || wr_addr !== 16'h0) begin failures++; $display("FAIL rst_async: got en=%b addr=%h expected 0 and 0000", wr_en, wr_addr); end
        cyc(0, 1, 8'($urandom)); cyc(0, 0, 0);
        rst_n = 1;
        for (int i = 0; i < 40; i++) cyc(0, 1'($urandom), 8'($urandom));
        for (int i = 0; i < 10; i++) cyc(1, 1'($urandom), 8'($urandom));
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rst_no_writes: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
        cyc(0, 0, 0);
        drive_line(0, 16, 0, 1);
        frame_end();
        bad = first_diff();
        checks++; if (got_q.size() != exp_q.size() || bad != -1) begin failures++; $display("FAIL rst_resume: got %0d writes expected %0d", got_q.size(), exp_q.size()); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_pre_vsync();
        test_byte_pair();
        test_full_frame();
        test_odd_line();
        test_random_frames();
        test_vsync_cut();
        test_overflow();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
